// File: rtl/panel_power_sequencer.sv
// Internal LCD panel power sequencer: orders panel power, LVDS drive and backlight
// with tick-based delays, and enforces a minimum off time before re-power.
module panel_power_sequencer #(
  parameter int CLK_DIV    = 33000,
  parameter int T_PWR_LVDS = 10,
  parameter int T_LVDS_BKL = 200,
  parameter int T_BKL_LVDS = 200,
  parameter int T_LVDS_PWR = 10,
  parameter int T_OFF_MIN  = 500,
  parameter int TW         = 10
) (
  input  logic       LPC_CLK33M_GMUX,
  input  logic       GMUX_RST,
  input  logic       LVDS_IG_PANEL_PWR,
  input  logic       LVDS_IG_BKL_ON,
  output logic       LCD_PWR_EN,
  output logic       LVDS_OUT_EN,
  output logic       LCD_BKLT_EN,
  output logic [2:0] SEQ_STATE,
  output logic       SEQ_BUSY
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWR_UP    = 3'd1,
    S_LVDS_ON   = 3'd2,
    S_BKL_ON    = 3'd3,
    S_BKL_DOWN  = 3'd4,
    S_LVDS_DOWN = 3'd5,
    S_OFF_HOLD  = 3'd6,
    S_BAD       = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      preq_sync_q, breq_sync_q;
  logic [PW-1:0]   pre_q;
  logic [TW-1:0]   tcnt_q;
  logic            pwr_q, lvds_q, bkl_q, busy_q;
  logic            preq, breq, tick;
  logic [TW:0]     tnow;
  logic            el_pwr_lvds, el_lvds_bkl, el_bkl_lvds, el_lvds_pwr, el_off_min;

  assign preq = preq_sync_q[1];
  assign breq = breq_sync_q[1];
  assign tick = (pre_q == PW'(CLK_DIV - 1));

  // Look ahead by the current tick so a state is left exactly T*CLK_DIV cycles after entry.
  assign tnow        = {1'b0, tcnt_q} + (TW+1)'(tick);
  assign el_pwr_lvds = (tnow >= (TW+1)'(T_PWR_LVDS));
  assign el_lvds_bkl = (tnow >= (TW+1)'(T_LVDS_BKL));
  assign el_bkl_lvds = (tnow >= (TW+1)'(T_BKL_LVDS));
  assign el_lvds_pwr = (tnow >= (TW+1)'(T_LVDS_PWR));
  assign el_off_min  = (tnow >= (TW+1)'(T_OFF_MIN));

  always_ff @(posedge LPC_CLK33M_GMUX) begin
    if (GMUX_RST) begin
      preq_sync_q <= '0;
      breq_sync_q <= '0;
    end else begin
      preq_sync_q <= {preq_sync_q[0], LVDS_IG_PANEL_PWR};
      breq_sync_q <= {breq_sync_q[0], LVDS_IG_BKL_ON};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:       if (preq) state_d = S_PWR_UP;
      S_PWR_UP:    if (!preq) state_d = S_OFF_HOLD;
                   else if (el_pwr_lvds) state_d = S_LVDS_ON;
      S_LVDS_ON:   if (!preq) state_d = S_LVDS_DOWN;
                   else if (breq && el_lvds_bkl) state_d = S_BKL_ON;
      S_BKL_ON:    if (!breq || !preq) state_d = S_BKL_DOWN;
      S_BKL_DOWN:  if (el_bkl_lvds) state_d = preq ? S_LVDS_ON : S_LVDS_DOWN;
      S_LVDS_DOWN: if (el_lvds_pwr) state_d = S_OFF_HOLD;
      S_OFF_HOLD:  if (el_off_min) state_d = S_OFF;
      default:     state_d = S_OFF_HOLD;
    endcase
  end

  always_ff @(posedge LPC_CLK33M_GMUX) begin
    if (GMUX_RST || (state_d != state_q)) begin
      pre_q  <= '0;
      tcnt_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick && (tcnt_q != '1)) tcnt_q <= tcnt_q + TW'(1);
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge LPC_CLK33M_GMUX) begin
    if (GMUX_RST) begin
      state_q <= S_OFF;
      pwr_q   <= 1'b0;
      lvds_q  <= 1'b0;
      bkl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwr_q   <= 1'b0;
      lvds_q  <= 1'b0;
      bkl_q   <= 1'b0;
      busy_q  <= 1'b0;
      case (state_d)
        S_PWR_UP:    begin pwr_q <= 1'b1; busy_q <= 1'b1; end
        S_LVDS_ON:   begin pwr_q <= 1'b1; lvds_q <= 1'b1; end
        S_BKL_ON:    begin pwr_q <= 1'b1; lvds_q <= 1'b1; bkl_q <= 1'b1; end
        S_BKL_DOWN:  begin pwr_q <= 1'b1; lvds_q <= 1'b1; busy_q <= 1'b1; end
        S_LVDS_DOWN: begin pwr_q <= 1'b1; busy_q <= 1'b1; end
        S_OFF_HOLD:  busy_q <= 1'b1;
        default:     ;
      endcase
    end
  end

  assign LCD_PWR_EN  = pwr_q;
  assign LVDS_OUT_EN = lvds_q;
  assign LCD_BKLT_EN = bkl_q;
  assign SEQ_STATE   = state_q;
  assign SEQ_BUSY    = busy_q;

endmodule

// File: tb/tb_panel_power_sequencer.sv
// Bench for panel_power_sequencer: directed timing table, corner sequences,
// then random requests against a cycle-counting reference model.
module tb_panel_power_sequencer;
  localparam int CLK_DIV = 4;
  localparam int T2 = 2, T3 = 3, T4 = 3, T5 = 2, T7 = 5;

  logic clk = 1'b0;
  logic rst, p, b;
  logic pwr, lvds, bkl, busy;
  logic [2:0] st;
  int checks = 0;
  int errors = 0;

  panel_power_sequencer #(
    .CLK_DIV(CLK_DIV), .T_PWR_LVDS(T2), .T_LVDS_BKL(T3), .T_BKL_LVDS(T4),
    .T_LVDS_PWR(T5), .T_OFF_MIN(T7), .TW(10)
  ) dut (
    .LPC_CLK33M_GMUX(clk), .GMUX_RST(rst), .LVDS_IG_PANEL_PWR(p), .LVDS_IG_BKL_ON(b),
    .LCD_PWR_EN(pwr), .LVDS_OUT_EN(lvds), .LCD_BKLT_EN(bkl), .SEQ_STATE(st), .SEQ_BUSY(busy)
  );

  always #5 clk = ~clk;

  // Reference model: requests delayed two cycles, dwell measured in raw clock cycles.
  int m = 0, cnt = 0;
  logic ps1 = 1'b0, ps2 = 1'b0, bs1 = 1'b0, bs2 = 1'b0;

  function automatic bit done(input int c, input int t);
    return (c + 1) >= t * CLK_DIV;
  endfunction

  function automatic int nxt(input int s, input int c, input bit pq, input bit bq);
    case (s)
      0: return pq ? 1 : 0;
      1: return !pq ? 6 : (done(c, T2) ? 2 : 1);
      2: return !pq ? 5 : ((bq && done(c, T3)) ? 3 : 2);
      3: return (!pq || !bq) ? 4 : 3;
      4: return done(c, T4) ? (pq ? 2 : 5) : 4;
      5: return done(c, T5) ? 6 : 5;
      6: return done(c, T7) ? 0 : 6;
      default: return 6;
    endcase
  endfunction

  // {PWR, LVDS, BKL, BUSY} for each state number
  function automatic logic [3:0] outs(input int s);
    case (s)
      1: return 4'b1001;
      2: return 4'b1100;
      3: return 4'b1110;
      4: return 4'b1101;
      5: return 4'b1001;
      6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m <= 0; cnt <= 0; ps1 <= 0; ps2 <= 0; bs1 <= 0; bs2 <= 0;
    end else begin
      m   <= nxt(m, cnt, ps2, bs2);
      cnt <= (nxt(m, cnt, ps2, bs2) != m) ? 0 : cnt + 1;
      ps1 <= p; ps2 <= ps1; bs1 <= b; bs2 <= bs1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("model_state", 32'(st), 32'(m));
      chk("model_outs", 32'({pwr, lvds, bkl, busy}), 32'(outs(m)));
      chk("invariant", 32'((!bkl || lvds) && (!lvds || pwr)), 32'd1);
    end
  endtask

  task automatic chk_st(input string nm, input int s, input logic [3:0] o);
    chk(nm, 32'(st), 32'(s));
    chk({nm, "_outs"}, 32'({pwr, lvds, bkl, busy}), 32'(o));
  endtask

  typedef struct {
    bit rst, p, b;
    int cyc;
    int st;
    logic [3:0] o;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst = 1'b1; p = 1'b0; b = 1'b0;
    // power-up then full power-down, hand-timed from the delay rules
    tbl[0]  = '{1, 0, 0, 2,  0, 4'b0000};
    tbl[1]  = '{0, 1, 1, 2,  0, 4'b0000};
    tbl[2]  = '{0, 1, 1, 1,  1, 4'b1001};
    tbl[3]  = '{0, 1, 1, 7,  1, 4'b1001};
    tbl[4]  = '{0, 1, 1, 1,  2, 4'b1100};
    tbl[5]  = '{0, 1, 1, 11, 2, 4'b1100};
    tbl[6]  = '{0, 1, 1, 1,  3, 4'b1110};
    tbl[7]  = '{0, 1, 1, 5,  3, 4'b1110};
    tbl[8]  = '{0, 0, 0, 2,  3, 4'b1110};
    tbl[9]  = '{0, 0, 0, 1,  4, 4'b1101};
    tbl[10] = '{0, 0, 0, 11, 4, 4'b1101};
    tbl[11] = '{0, 0, 0, 1,  5, 4'b1001};
    tbl[12] = '{0, 0, 0, 7,  5, 4'b1001};
    tbl[13] = '{0, 0, 0, 1,  6, 4'b0001};
    tbl[14] = '{0, 0, 0, 19, 6, 4'b0001};
    tbl[15] = '{0, 0, 0, 1,  0, 4'b0000};
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; p = tbl[i].p; b = tbl[i].b;
      step(tbl[i].cyc);
      chk($sformatf("tbl%0d", i), 32'({st, pwr, lvds, bkl, busy}), 32'({tbl[i].st[2:0], tbl[i].o}));
    end

    // abort during PWR_UP: LVDS must never assert
    p = 1; step(3); chk_st("abort_up", 1, 4'b1001);
    step(4); p = 0;
    step(3); chk_st("abort_hold", 6, 4'b0001);
    step(19); chk_st("abort_hold_end", 6, 4'b0001);
    step(1); chk_st("abort_off", 0, 4'b0000);

    // min-off: request held through OFF_HOLD re-powers one cycle after OFF
    p = 1; step(3); chk_st("minoff_up", 1, 4'b1001);
    p = 0; step(3); chk_st("minoff_hold", 6, 4'b0001);
    p = 1; step(19); chk_st("minoff_still", 6, 4'b0001);
    step(1); chk_st("minoff_off", 0, 4'b0000);
    step(1); chk_st("minoff_repwr", 1, 4'b1001);
    p = 0; step(25); chk_st("minoff_done", 0, 4'b0000);

    // backlight toggle with power held
    p = 1; b = 1; step(23); chk_st("tog_on", 3, 4'b1110);
    b = 0; step(1); b = 1; step(2); chk_st("tog_down", 4, 4'b1101);
    step(11); chk_st("tog_down_end", 4, 4'b1101);
    step(1); chk_st("tog_lvds", 2, 4'b1100);
    step(11); chk_st("tog_lvds_end", 2, 4'b1100);
    step(1); chk_st("tog_bkl", 3, 4'b1110);

    // reset from BKL_ON drops everything next cycle
    rst = 1; step(1); chk_st("rst_bkl", 0, 4'b0000);
    rst = 0;

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) p = ~p;
      if ($urandom_range(0, 19) == 0) b = ~b;
      rst = ($urandom_range(0, 799) == 0);
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
